// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one ALU_32 between two requesters. Ownership is granted with a
// round-robin tie-break. An owner is preempted after MAX_BURST accepted ops
// while the other side waits. When CLEAR_ON_SWITCH is set, every ownership
// change is preceded by one ALU_CLEAR cycle so that a new owner starts from
// an empty accumulator.
//
// Ports
//   clk, reset           clock (rising edge), asynchronous active-high reset
//   reqN, opN, bN        requester N: ownership request, ALU opcode, B operand
//   gntN                 requester N owns the ALU this cycle
//   rsp_validN           result of requester N's op from the previous cycle is
//                        on result/z
//   alu_instruction      opcode to ALU_32
//   alu_b                B operand to ALU_32
//   alu_a, alu_z         accumulator and zero flag from ALU_32
//   result, z            combinational pass-through of alu_a / alu_z
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int          MAX_BURST       = 8,
  parameter bit          CLEAR_ON_SWITCH = 1'b1,
  parameter logic [7:0]  ALU_CLEAR       = 8'd0,
  parameter logic [7:0]  ALU_NOP         = 8'd9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [7:0]  op0,
  input  logic [31:0] b0,
  output logic        gnt0,
  output logic        rsp_valid0,
  input  logic        req1,
  input  logic [7:0]  op1,
  input  logic [31:0] b1,
  output logic        gnt1,
  output logic        rsp_valid1,
  output logic [7:0]  alu_instruction,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_a,
  input  logic        alu_z,
  output logic [31:0] result,
  output logic        z
);

  localparam logic [7:0] L_MAX_BURST = 8'(MAX_BURST);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SWITCH = 2'd1,
    S_OWN0   = 2'd2,
    S_OWN1   = 2'd3
  } state_t;

  state_t     r_state, w_state_nxt;
  logic       r_prio, w_prio_nxt;
  logic       r_next_owner, w_next_owner_nxt;
  logic [7:0] r_burst_cnt, w_burst_cnt_nxt;
  logic       r_rsp_valid0, r_rsp_valid1;

  logic       w_own1;       // index of the current owner when in an OWN state
  logic       w_req_own;
  logic       w_req_oth;
  logic       w_accept0;
  logic       w_accept1;
  logic       w_accept;
  logic [7:0] w_cnt_inc;
  logic       w_burst_hit;
  logic       w_grant_en;
  logic       w_grant_to;

  assign w_own1    = (r_state == S_OWN1);
  assign w_req_own = w_own1 ? req1 : req0;
  assign w_req_oth = w_own1 ? req0 : req1;
  assign w_accept0 = (r_state == S_OWN0) && (op0 != ALU_NOP);
  assign w_accept1 = (r_state == S_OWN1) && (op1 != ALU_NOP);
  assign w_accept  = w_accept0 || w_accept1;

  // Saturating burst count including this cycle's op. Preemption looks at this
  // value so the owner leaves right after its MAX_BURST-th accepted op rather
  // than getting one extra op in.
  assign w_cnt_inc   = (w_accept && (r_burst_cnt != L_MAX_BURST)) ?
                       (r_burst_cnt + 8'd1) : r_burst_cnt;
  assign w_burst_hit = (w_cnt_inc == L_MAX_BURST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_prio       <= 1'b0;
      r_next_owner <= 1'b0;
      r_burst_cnt  <= 8'd0;
      r_rsp_valid0 <= 1'b0;
      r_rsp_valid1 <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_prio       <= w_prio_nxt;
      r_next_owner <= w_next_owner_nxt;
      r_burst_cnt  <= w_burst_cnt_nxt;
      r_rsp_valid0 <= w_accept0;
      r_rsp_valid1 <= w_accept1;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt      = r_state;
    w_prio_nxt       = r_prio;
    w_next_owner_nxt = r_next_owner;
    w_burst_cnt_nxt  = r_burst_cnt;
    w_grant_en       = 1'b0;
    w_grant_to       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (req0 || req1) begin
          w_grant_en = 1'b1;
          w_grant_to = (req0 && req1) ? r_prio : req1;
        end
      end
      S_SWITCH: begin
        w_state_nxt     = r_next_owner ? S_OWN1 : S_OWN0;
        w_burst_cnt_nxt = 8'd0;
      end
      default: begin  // S_OWN0 / S_OWN1
        w_burst_cnt_nxt = w_cnt_inc;
        if (!w_req_own || (w_burst_hit && w_req_oth)) begin
          if (w_req_oth) begin
            w_grant_en = 1'b1;
            w_grant_to = ~w_own1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
    endcase

    // Common grant path: flip priority away from the winner and either go
    // through the clear cycle or straight into ownership.
    if (w_grant_en) begin
      w_prio_nxt = ~w_grant_to;
      if (CLEAR_ON_SWITCH) begin
        w_state_nxt      = S_SWITCH;
        w_next_owner_nxt = w_grant_to;
      end else begin
        w_state_nxt     = w_grant_to ? S_OWN1 : S_OWN0;
        w_burst_cnt_nxt = 8'd0;
      end
    end
  end

  // Output logic
  always_comb begin
    gnt0            = 1'b0;
    gnt1            = 1'b0;
    alu_instruction = ALU_NOP;
    alu_b           = 32'd0;
    case (r_state)
      S_OWN0: begin
        gnt0            = 1'b1;
        alu_instruction = op0;
        alu_b           = b0;
      end
      S_OWN1: begin
        gnt1            = 1'b1;
        alu_instruction = op1;
        alu_b           = b1;
      end
      S_SWITCH: begin
        alu_instruction = ALU_CLEAR;
      end
      default: begin
        alu_instruction = ALU_NOP;
      end
    endcase
  end

  assign rsp_valid0 = r_rsp_valid0;
  assign rsp_valid1 = r_rsp_valid1;
  assign result     = alu_a;
  assign z          = alu_z;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
// Two arbiter instances, each driving a small behavioural accumulator model:
//   A: MAX_BURST=3, CLEAR_ON_SWITCH=1 (table-driven vectors)
//   B: MAX_BURST=1, CLEAR_ON_SWITCH=0 (hand-written sequence)
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam logic [7:0] C = 8'd0;  // CLEAR
  localparam logic [7:0] L = 8'd1;  // LOAD B
  localparam logic [7:0] I = 8'd2;  // INC
  localparam logic [7:0] D = 8'd3;  // DIV16
  localparam logic [7:0] N = 8'd9;  // NOP

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A ----------------
  logic        a_rst, a_req0, a_req1, a_gnt0, a_gnt1, a_v0, a_v1, a_z, a_az;
  logic [7:0]  a_op0, a_op1, a_ins;
  logic [31:0] a_b0, a_b1, a_alub, a_acc, a_res;

  alu_arbiter #(.MAX_BURST(3), .CLEAR_ON_SWITCH(1'b1)) u_a (
    .clk(clk), .reset(a_rst),
    .req0(a_req0), .op0(a_op0), .b0(a_b0), .gnt0(a_gnt0), .rsp_valid0(a_v0),
    .req1(a_req1), .op1(a_op1), .b1(a_b1), .gnt1(a_gnt1), .rsp_valid1(a_v1),
    .alu_instruction(a_ins), .alu_b(a_alub), .alu_a(a_acc), .alu_z(a_az),
    .result(a_res), .z(a_z)
  );

  // ---------------- instance B ----------------
  logic        b_rst, b_req0, b_req1, b_gnt0, b_gnt1, b_v0, b_v1, b_z, b_az;
  logic [7:0]  b_op0, b_op1, b_ins;
  logic [31:0] b_b0, b_b1, b_alub, b_acc, b_res;

  alu_arbiter #(.MAX_BURST(1), .CLEAR_ON_SWITCH(1'b0)) u_b (
    .clk(clk), .reset(b_rst),
    .req0(b_req0), .op0(b_op0), .b0(b_b0), .gnt0(b_gnt0), .rsp_valid0(b_v0),
    .req1(b_req1), .op1(b_op1), .b1(b_b1), .gnt1(b_gnt1), .rsp_valid1(b_v1),
    .alu_instruction(b_ins), .alu_b(b_alub), .alu_a(b_acc), .alu_z(b_az),
    .result(b_res), .z(b_z)
  );

  // Registered accumulator standing in for ALU_32.
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [7:0] ins,
                                        input logic [31:0] b);
    case (ins)
      8'd0:    return 32'd0;
      8'd1:    return b;
      8'd2:    return a + 32'd1;
      8'd3:    return a >> 4;
      default: return a;
    endcase
  endfunction

  always_ff @(posedge clk or posedge a_rst)
    if (a_rst) a_acc <= 32'd0; else a_acc <= alu_f(a_acc, a_ins, a_alub);
  always_ff @(posedge clk or posedge b_rst)
    if (b_rst) b_acc <= 32'd0; else b_acc <= alu_f(b_acc, b_ins, b_alub);
  assign a_az = (a_acc == 32'd0);
  assign b_az = (b_acc == 32'd0);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        r0;
    logic [7:0]  o0;
    logic [31:0] b0;
    logic        r1;
    logic [7:0]  o1;
    logic [31:0] b1;
    logic        g0, g1, v0, v1;
    logic [7:0]  ins;
    logic [31:0] ab;
    logic [31:0] res;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic rst, input logic r0, input logic [7:0] o0,
                     input logic [31:0] b0, input logic r1, input logic [7:0] o1,
                     input logic [31:0] b1, input logic g0, input logic g1,
                     input logic v0, input logic v1, input logic [7:0] ins,
                     input logic [31:0] ab, input logic [31:0] res);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.o0 = o0; v.b0 = b0; v.r1 = r1; v.o1 = o1; v.b1 = b1;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.ins = ins; v.ab = ab; v.res = res;
    vt.push_back(v);
  endtask

  task automatic b_drive(input logic r0, input logic [7:0] o0, input logic [31:0] bb0,
                         input logic r1, input logic [7:0] o1);
    @(negedge clk);
    b_req0 = r0; b_op0 = o0; b_b0 = bb0; b_req1 = r1; b_op1 = o1; b_b1 = 32'd0;
    #1;
  endtask

  initial begin
    a_rst = 1'b1; a_req0 = 0; a_req1 = 0; a_op0 = N; a_op1 = N; a_b0 = 0; a_b1 = 0;
    b_rst = 1'b1; b_req0 = 0; b_req1 = 0; b_op0 = N; b_op1 = N; b_b0 = 0; b_b1 = 0;

    //   rst r0 o0 b0   r1 o1 b1 | g0 g1 v0 v1 ins ab  res
    // single owner: LOAD 255, DIV16
    add(0, 0, N, 0,   0, N, 0,   0, 0, 0, 0, N, 0,   0);
    add(0, 1, L, 255, 0, N, 0,   0, 0, 0, 0, N, 0,   0);
    add(0, 1, L, 255, 0, N, 0,   0, 0, 0, 0, C, 0,   0);
    add(0, 1, L, 255, 0, N, 0,   1, 0, 0, 0, L, 255, 0);
    add(0, 1, D, 0,   0, N, 0,   1, 0, 1, 0, D, 0,   255);
    add(0, 1, N, 0,   0, N, 0,   1, 0, 1, 0, N, 0,   15);
    add(0, 0, N, 0,   0, N, 0,   1, 0, 0, 0, N, 0,   15);
    add(0, 0, N, 0,   0, N, 0,   0, 0, 0, 0, N, 0,   15);
    // tie after reset, req0 releases on first owned cycle, then 1 does CLEAR/INC
    add(1, 0, N, 0,   0, N, 0,   0, 0, 0, 0, N, 0,   0);
    add(0, 1, N, 0,   1, N, 0,   0, 0, 0, 0, N, 0,   0);
    add(0, 1, N, 0,   1, N, 0,   0, 0, 0, 0, C, 0,   0);
    add(0, 0, N, 0,   1, N, 0,   1, 0, 0, 0, N, 0,   0);
    add(0, 0, N, 0,   1, C, 0,   0, 0, 0, 0, C, 0,   0);
    add(0, 0, N, 0,   1, C, 0,   0, 1, 0, 0, C, 0,   0);
    add(0, 0, N, 0,   1, I, 0,   0, 1, 0, 1, I, 0,   0);
    add(0, 0, N, 0,   0, N, 0,   0, 1, 0, 1, N, 0,   1);
    add(0, 0, N, 0,   0, N, 0,   0, 0, 0, 0, N, 0,   1);
    // burst preemption after 3 INCs, then regrant to 0 from result 0
    add(1, 0, N, 0,   0, N, 0,   0, 0, 0, 0, N, 0,   0);
    add(0, 1, I, 0,   1, N, 0,   0, 0, 0, 0, N, 0,   0);
    add(0, 1, I, 0,   1, N, 0,   0, 0, 0, 0, C, 0,   0);
    add(0, 1, I, 0,   1, N, 0,   1, 0, 0, 0, I, 0,   0);
    add(0, 1, I, 0,   1, N, 0,   1, 0, 1, 0, I, 0,   1);
    add(0, 1, I, 0,   1, N, 0,   1, 0, 1, 0, I, 0,   2);
    add(0, 1, I, 0,   1, I, 0,   0, 0, 1, 0, C, 0,   3);
    add(0, 1, I, 0,   1, I, 0,   0, 1, 0, 0, I, 0,   0);
    add(0, 1, I, 0,   0, N, 0,   0, 1, 0, 1, N, 0,   1);
    add(0, 1, I, 0,   0, N, 0,   0, 0, 0, 0, C, 0,   1);
    add(0, 1, I, 0,   0, N, 0,   1, 0, 0, 0, I, 0,   0);
    add(0, 0, N, 0,   0, N, 0,   1, 0, 1, 0, N, 0,   1);
    add(0, 0, N, 0,   0, N, 0,   0, 0, 0, 0, N, 0,   1);
    // reset while 1 owns with INC in flight; next tie goes to 0
    add(0, 0, N, 0,   1, I, 0,   0, 0, 0, 0, N, 0,   1);
    add(0, 0, N, 0,   1, I, 0,   0, 0, 0, 0, C, 0,   1);
    add(0, 0, N, 0,   1, I, 0,   0, 1, 0, 0, I, 0,   0);
    add(1, 0, N, 0,   1, I, 0,   0, 0, 0, 0, N, 0,   0);
    add(0, 1, N, 0,   1, N, 0,   0, 0, 0, 0, N, 0,   0);
    add(0, 1, N, 0,   1, N, 0,   0, 0, 0, 0, C, 0,   0);
    add(0, 0, N, 0,   0, N, 0,   1, 0, 0, 0, N, 0,   0);
    add(0, 0, N, 0,   0, N, 0,   0, 0, 0, 0, N, 0,   0);

    repeat (2) @(posedge clk);

    foreach (vt[i]) begin
      @(negedge clk);
      a_rst = vt[i].rst;
      a_req0 = vt[i].r0; a_op0 = vt[i].o0; a_b0 = vt[i].b0;
      a_req1 = vt[i].r1; a_op1 = vt[i].o1; a_b1 = vt[i].b1;
      #1;
      chk($sformatf("A[%0d] gnt0", i),       32'(a_gnt0), 32'(vt[i].g0));
      chk($sformatf("A[%0d] gnt1", i),       32'(a_gnt1), 32'(vt[i].g1));
      chk($sformatf("A[%0d] rsp_valid0", i), 32'(a_v0),   32'(vt[i].v0));
      chk($sformatf("A[%0d] rsp_valid1", i), 32'(a_v1),   32'(vt[i].v1));
      chk($sformatf("A[%0d] alu_instr", i),  32'(a_ins),  32'(vt[i].ins));
      chk($sformatf("A[%0d] alu_b", i),      a_alub,      vt[i].ab);
      chk($sformatf("A[%0d] result", i),     a_res,       vt[i].res);
      chk($sformatf("A[%0d] z", i),          32'(a_z),    32'(vt[i].res == 32'd0));
    end

    // ---- instance B: NOPs not counted (MAX_BURST=1), no clear on handoff ----
    @(negedge clk);
    b_rst = 1'b0;
    b_drive(1, N, 0, 0, N);
    chk("B idle gnt0", 32'(b_gnt0), 32'd0);
    for (int k = 0; k < 5; k++) begin
      b_drive(1, N, 0, 1, N);
      chk($sformatf("B nop%0d gnt0", k), 32'(b_gnt0), 32'd1);
      chk($sformatf("B nop%0d gnt1", k), 32'(b_gnt1), 32'd0);
      chk($sformatf("B nop%0d rsp0", k), 32'(b_v0),   32'd0);
    end
    b_drive(1, I, 0, 1, N);
    chk("B inc gnt0",  32'(b_gnt0), 32'd1);
    chk("B inc instr", 32'(b_ins),  32'(I));
    chk("B inc rsp0",  32'(b_v0),   32'd0);
    b_drive(0, N, 0, 0, N);
    chk("B pre gnt0",   32'(b_gnt0), 32'd0);
    chk("B pre gnt1",   32'(b_gnt1), 32'd1);
    chk("B pre rsp0",   32'(b_v0),   32'd1);
    chk("B pre result", b_res,       32'd1);
    b_drive(1, L, 456, 0, N);
    chk("B idle2 gnt0",   32'(b_gnt0), 32'd0);
    chk("B idle2 gnt1",   32'(b_gnt1), 32'd0);
    chk("B idle2 result", b_res,       32'd1);
    b_drive(1, L, 456, 1, N);
    chk("B load gnt0",  32'(b_gnt0), 32'd1);
    chk("B load alu_b", b_alub,      32'd456);
    b_drive(1, N, 0, 0, N);
    chk("B hand gnt0",   32'(b_gnt0), 32'd0);
    chk("B hand gnt1",   32'(b_gnt1), 32'd1);
    chk("B hand rsp0",   32'(b_v0),   32'd1);
    chk("B hand result", b_res,       32'd456);
    chk("B hand instr",  32'(b_ins),  32'(N));
    b_drive(0, N, 0, 0, N);
    chk("B back gnt0",   32'(b_gnt0), 32'd1);
    chk("B back result", b_res,       32'd456);
    chk("B back z",      32'(b_z),    32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
